// File: rtl/regfile_dump_pkg.sv
// Shared types and sizing for the register-file UART dump engine.
package regfile_dump_pkg;

   localparam int NUM_REGS        = 32;
   localparam int BYTES_PER_WORD  = 4;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      CAPTURE,
      SEND,
      NEXT
   } dump_state_t;

endpackage

// File: rtl/regfile_dump_uart_uart_tx.sv
// uart_tx: 8N1 serialiser; start bit appears the edge after send is accepted, frame is 10 bit periods.
// ready is high while idle and in the last stop-bit cycle, so a queued byte follows with no gap.
module uart_tx
   import regfile_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       send,
   output logic       tx,
   output logic       ready
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic          active;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic          bit_end;
   logic          frame_end;

   assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign frame_end = active && bit_end && (bit_cnt == 4'(UART_FRAME_BITS - 1));
   assign ready     = !active || frame_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else if (send && ready) begin
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= data;
         tx       <= 1'b0;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (frame_end) begin
               active <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               // bit_cnt 0..7 selects the data bit about to go out; 8 leads into the stop bit
               tx      <= (bit_cnt == 4'd8) ? 1'b1 : shift[bit_cnt[2:0]];
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_dump_uart.sv
// regfile_dump_uart: sweeps x0..x31 through the debug read port, sends each word LE as 8N1 (PC word first with DUMP_PC_EN).
// First start bit 3 cycles after accept (1 with DUMP_PC_EN), 3 idle cycles between words; start ignored while busy.
module regfile_dump_uart
   import regfile_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] Debug_out,
   input  logic [31:0] PC,
   output logic [4:0]  Debug_Source_select,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   dump_state_t state, state_nxt;
   logic [4:0]  index;
   logic [31:0] word;
   logic [1:0]  byte_cnt;
   logic        pc_phase;
   logic        last_word;
   logic        uart_send;
   logic        uart_ready;
   logic [7:0]  uart_data;

`ifndef DUMP_PC_EN
   logic pc_unused;
   assign pc_unused = ^PC;
`endif

   assign last_word           = !pc_phase && (index == 5'(NUM_REGS - 1));
   assign uart_data           = word[{byte_cnt, 3'b000} +: 8];
   assign Debug_Source_select = (state == IDLE) ? 5'd0 : index;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk  (clk),
      .reset(reset),
      .data (uart_data),
      .send (uart_send),
      .tx   (tx),
      .ready(uart_ready)
   );

   // NEXT is left in the final stop-bit cycle so only SELECT, CAPTURE and launch sit idle between words
   always_comb begin
      state_nxt = state;
      uart_send = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef DUMP_PC_EN
               state_nxt = SEND;
`else
               state_nxt = SELECT;
`endif
            end
         end
         SELECT:  state_nxt = CAPTURE;
         CAPTURE: state_nxt = SEND;
         SEND: begin
            uart_send = 1'b1;
            if (uart_ready && (byte_cnt == 2'(BYTES_PER_WORD - 1))) begin
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            if (uart_ready) begin
               state_nxt = last_word ? IDLE : SELECT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         index    <= '0;
         word     <= '0;
         byte_cnt <= '0;
         pc_phase <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  index    <= '0;
                  byte_cnt <= '0;
                  busy     <= 1'b1;
`ifdef DUMP_PC_EN
                  word     <= PC;
                  pc_phase <= 1'b1;
`endif
               end
            end
            CAPTURE: word <= Debug_out;
            SEND: begin
               if (uart_ready) begin
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            NEXT: begin
               if (uart_ready) begin
                  if (last_word) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else if (pc_phase) begin
                     pc_phase <= 1'b0;
                  end else begin
                     index <= index + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_uart.sv
// Bench for regfile_dump_uart: register-file model on the debug port, UART decoder monitor against an expected-byte queue.
`timescale 1ns/1ps
module tb_regfile_dump_uart;
   localparam int C    = 4;
   localparam int HALF = 5;
`ifdef DUMP_PC_EN
   localparam int NWORDS    = 33;
   localparam int FIRST_LAT = 1;
`else
   localparam int NWORDS    = 32;
   localparam int FIRST_LAT = 3;
`endif
   localparam int NBYTES      = NWORDS * 4;
   localparam int DUMP_CYCLES = FIRST_LAT + NWORDS * 40 * C + (NWORDS - 1) * 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] PC;
   logic [4:0]  sel;
   logic        tx;
   logic        busy;
   logic        done;
   logic [31:0] regs [32];
   logic [31:0] Debug_out;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int rx_cnt   = 0;
   int cyc      = 0;
   logic [7:0] exp_q [$];

   assign Debug_out = regs[sel];

   always #HALF clk = ~clk;

   regfile_dump_uart #(.CLKS_PER_BIT(C)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .Debug_out          (Debug_out),
      .PC                 (PC),
      .Debug_Source_select(sel),
      .tx                 (tx),
      .busy               (busy),
      .done               (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
   end

   // Expected stream: optional PC word, then x0..x31, each little-endian
   task automatic push_expected(output logic [7:0] first);
      logic [7:0] b;
      bit got;
      got   = 0;
      first = '0;
`ifdef DUMP_PC_EN
      for (int k = 0; k < 4; k++) begin
         b = 8'((PC >> (8 * k)) & 32'hFF);
         exp_q.push_back(b);
         if (!got) begin first = b; got = 1; end
      end
`endif
      for (int r = 0; r < 32; r++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'((regs[r] >> (8 * k)) & 32'hFF);
            exp_q.push_back(b);
            if (!got) begin first = b; got = 1; end
         end
      end
   endtask

   // UART receiver: samples each bit at its centre on the falling clock edge
   initial begin : uart_monitor
      logic       prev;
      logic       bad;
      logic       stop;
      logic [7:0] rx;
      logic [7:0] e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1 && prev === 1'b1 && tx === 1'b0) begin
            bad  = 1'b0;
            rx   = '0;
            stop = 1'b0;
            repeat (C / 2) @(negedge clk);
            if (reset !== 1'b0) bad = 1'b1;
            for (int k = 1; k <= 9; k++) begin
               repeat (C) @(negedge clk);
               if (reset !== 1'b0) bad = 1'b1;
               if (k <= 8) rx[k-1] = tx;
               else stop = tx;
            end
            if (!bad) begin
               check("stop_bit", 32'(stop), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte actual=0x%0h required=none", rx);
               end else begin
                  e = exp_q.pop_front();
                  check("uart_byte", 32'(rx), 32'(e));
               end
               rx_cnt++;
            end
         end
         prev = tx;
      end
   end

   task automatic start_dump(input bit hold, output int acc, output int dc0, output int rx0,
                             output logic [7:0] first);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin tick(); n++; end
      @(negedge clk);
      start = 1'b1;
      dc0 = done_cnt;
      rx0 = rx_cnt;
      @(posedge clk);
      push_expected(first);
      #1;
      acc = cyc;
      if (!hold) start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int acc, input int dc0, input int rx0);
      int n;
      int d;
      n = 0;
      while (done !== 1'b1 && n < DUMP_CYCLES + 100) begin tick(); n++; end
      d = cyc - acc;
      checks++;
      if (done !== 1'b1 || d < DUMP_CYCLES - 1 || d > DUMP_CYCLES + 1) begin
         errors++;
         $display("FAIL dump_cycles actual=%0d required=%0d", d, DUMP_CYCLES);
      end
      check("busy_at_done", 32'(busy), 32'd0);
      tick();
      check("done_width", 32'(done), 32'd0);
      check("sel_idle", 32'(sel), 32'd0);
      repeat (20) tick();
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_count", 32'(done_cnt - dc0), 32'd1);
      check("byte_count", 32'(rx_cnt - rx0), 32'(NBYTES));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int acc, dc0, rx0, lat, lows, highs, tz, n;
      logic [7:0] fb;
      reset = 1'b1;
      start = 1'b0;
      PC    = 32'h0000_0040;
      for (int i = 0; i < 32; i++) regs[i] = 32'h1111_0000 + 32'(i);

      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) tick();
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      // Dump 1: known pattern, start-bit latency and first-frame bit timing
      start_dump(0, acc, dc0, rx0, fb);
      lat = 0;
      while (tx !== 1'b0 && lat < 20) begin tick(); lat++; end
      check("start_latency", 32'(lat), 32'(FIRST_LAT));
      tz = 0;
      for (int b = 0; b < 8; b++) begin
         if (fb[b]) break;
         tz++;
      end
      lows = 0;
      while (tx === 1'b0 && lows < 100) begin tick(); lows++; end
      check("first_low_run", 32'(lows), 32'(C * (1 + tz)));
      highs = 0;
      while (tx === 1'b1 && highs < 100) begin tick(); highs++; end
      check("first_high_run", 32'(highs), 32'(C));
      wait_done(acc, dc0, rx0);

      // Dump 2: random data, start held then re-pulsed while busy, x5 source changes after capture
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      PC = $urandom();
      start_dump(1, acc, dc0, rx0, fb);
      fork
         begin
            repeat (2000) @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
            start = 1'b1;
            repeat (3) @(negedge clk);
            start = 1'b0;
         end
         begin
            int m;
            m = 0;
            while (sel !== 5'd5 && m < 3000) begin tick(); m++; end
            check("x5_selected", 32'(sel), 32'd5);
            @(posedge clk);
            @(posedge clk);
            #1 regs[5] = ~regs[5];
         end
         wait_done(acc, dc0, rx0);
      join

      // Dump 3: reset while byte 2 of x7 is on the line
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      start_dump(0, acc, dc0, rx0, fb);
      n = 0;
      while (sel !== 5'd7 && n < 3000) begin tick(); n++; end
      check("x7_selected", 32'(sel), 32'd7);
      repeat (100) tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      repeat (8) tick();
      check("rst_mid_sel", 32'(sel), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (60) tick();
      check("rst_no_done", 32'(done_cnt - dc0), 32'd0);
      check("rst_stays_idle", 32'(busy), 32'd0);

      // Dump 4: fresh random data, must restart from the beginning
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      PC = $urandom();
      start_dump(0, acc, dc0, rx0, fb);
      wait_done(acc, dc0, rx0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
